// File: rtl/onehot_dispatch_pkg.sv
// Shared types, default sizing constants and the index-to-line decoder for onehot_dispatch.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package onehot_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_IDX_W   = 3;
  localparam int DEF_HOLD    = 4;
  localparam int DEF_TIMEOUT = 16;

  // Widest decode the helper supports; callers size-cast down to their own N.
  localparam int MAX_N = 256;

  function automatic logic [MAX_N-1:0] onehot(input logic [7:0] idx);
    logic [MAX_N-1:0] one;
    one = {{(MAX_N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/dispatch_hold_counter.sv
// Loadable down-counter with zero flag; shared by the line-hold and WAIT-timeout counts.
// Latency: load/dec take effect at the next clock edge; zero_o is decoded from the register.
// Backpressure: none; load has priority over dec.
//
// Ports: clk, rst_n (async active-low), load_i/load_val_i (preset), dec_i (count down
// when nonzero), zero_o (count register is zero).
module dispatch_hold_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/onehot_dispatch.sv
// Index-to-line dispatcher: accepts a binary index, drives its one-hot line for HOLD cycles,
// waits for that line's ack, then pulses done_o. Accept-to-accept spacing is at least HOLD+2.
// Backpressure: in_ready is high only in IDLE with en set; the source holds in_valid/in_idx.
//
// Ports: clk, rst_n (async active-low); en, in_valid/in_ready/in_idx (request handshake);
// ack_i (per-line level ack); y (registered one-hot drive); done_o/done_idx (completion);
// timeout_o (abort pulse).
// Build option: define ONEHOT_DISPATCH_TIMEOUT_EN to bound WAIT to TIMEOUT cycles; without
// it WAIT is unbounded and timeout_o is tied low.
module onehot_dispatch
  import onehot_dispatch_pkg::*;
#(
  parameter int IDX_W   = DEF_IDX_W,
  parameter int HOLD    = DEF_HOLD,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic [(1<<IDX_W)-1:0] ack_i,
  output logic [(1<<IDX_W)-1:0] y,
  output logic                  done_o,
  output logic [IDX_W-1:0]      done_idx,
  output logic                  timeout_o
);

  localparam int N       = 1 << IDX_W;
  localparam int CNT_MAX = (HOLD > TIMEOUT) ? HOLD : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     y_q, y_d;
  logic             ack_seen_q, ack_seen_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] done_idx_q, done_idx_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             ack_hit;

`ifdef ONEHOT_DISPATCH_TIMEOUT_EN
  logic timeout_q, timeout_d;
`endif

  // Only the addressed line's ack matters; all other lines are ignored.
  assign ack_hit = ack_i[idx_q];

  // Gated by rst_n so the source never sees ready while the block is held in reset.
  assign in_ready = (state_q == IDLE) && en && rst_n;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    y_d          = y_q;
    ack_seen_d   = ack_seen_q;
    done_d       = 1'b0;
    done_idx_d   = done_idx_q;
    cnt_load     = 1'b0;
    cnt_load_val = CNT_W'(HOLD - 1);
    cnt_dec      = 1'b0;
`ifdef ONEHOT_DISPATCH_TIMEOUT_EN
    timeout_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          idx_d      = in_idx;
          y_d        = N'(onehot(8'(in_idx)));
          ack_seen_d = 1'b0;
          cnt_load   = 1'b1;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (ack_hit) ack_seen_d = 1'b1;
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          y_d = '0;
          // An ack caught at any point of the hold, including its last cycle, skips WAIT.
          if (ack_seen_q || ack_hit) begin
            state_d    = DONE;
            done_d     = 1'b1;
            done_idx_d = idx_q;
          end else begin
            state_d = WAIT;
`ifdef ONEHOT_DISPATCH_TIMEOUT_EN
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(TIMEOUT - 1);
`endif
          end
        end
      end
      WAIT: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (ack_hit) begin
          state_d    = DONE;
          done_d     = 1'b1;
          done_idx_d = idx_q;
`ifdef ONEHOT_DISPATCH_TIMEOUT_EN
        end else if (cnt_zero) begin
          state_d    = IDLE;
          timeout_d  = 1'b1;
          done_idx_d = idx_q;
        end else begin
          cnt_dec = 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        y_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      y_q        <= '0;
      ack_seen_q <= 1'b0;
      done_q     <= 1'b0;
      done_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      y_q        <= y_d;
      ack_seen_q <= ack_seen_d;
      done_q     <= done_d;
      done_idx_q <= done_idx_d;
    end
  end

`ifdef ONEHOT_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_q <= 1'b0;
    else        timeout_q <= timeout_d;
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  dispatch_hold_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign y        = y_q;
  assign done_o   = done_q;
  assign done_idx = done_idx_q;

endmodule

// File: tb/tb_onehot_dispatch.sv
// Directed self-checking bench for onehot_dispatch (IDX_W=3, HOLD=4, TIMEOUT=16).
// Inputs change and outputs are sampled 1ns after each rising edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_onehot_dispatch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_idx = 3'd0;
  logic [7:0] ack_i = 8'h00;
  logic [7:0] y;
  logic       done_o;
  logic [2:0] done_idx;
  logic       timeout_o;

  int checks = 0;
  int errors = 0;

  onehot_dispatch #(
    .IDX_W   (3),
    .HOLD    (4),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .ack_i     (ack_i),
    .y         (y),
    .done_o    (done_o),
    .done_idx  (done_idx),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present an index and let the next edge accept it; returns just after that edge.
  task automatic accept(input logic [2:0] idx);
    en       = 1'b1;
    in_idx   = idx;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en    = 1'b1;
    step();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h want 00", y); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++; if (done_idx !== 3'd0) begin errors++; $display("FAIL reset_done_idx: got %0d want 0", done_idx); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", in_ready); end
    step();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL idle_y: got %h want 00", y); end
  endtask

  task automatic test_basic_dispatch;
    accept(3'd5);
    // Four cycles of drive after the accepting edge.
    for (int i = 0; i < 4; i++) begin
      checks++; if (y !== 8'h20) begin errors++; $display("FAIL basic_y_hold%0d: got %h want 20", i, y); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_busy%0d: got %b want 0", i, in_ready); end
      step();
    end
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL basic_y_drop: got %h want 00", y); end
    step();
    step();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b want 0", done_o); end
    ack_i = 8'h20;
    step();
    ack_i = 8'h00;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done_o); end
    checks++; if (done_idx !== 3'd5) begin errors++; $display("FAIL basic_done_idx: got %0d want 5", done_idx); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_done: got %b want 0", in_ready); end
    step();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done_o); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_early_and_wrong_ack;
    ack_i = 8'h40;
    accept(3'd2);
    ack_i = 8'h44;
    step();
    ack_i = 8'h40;
    step();
    step();
    checks++; if (y !== 8'h04) begin errors++; $display("FAIL early_y_last: got %h want 04", y); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL early_done_in_drive: got %b want 0", done_o); end
    step();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL early_y_drop: got %h want 00", y); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL early_done: got %b want 1", done_o); end
    checks++; if (done_idx !== 3'd2) begin errors++; $display("FAIL early_done_idx: got %0d want 2", done_idx); end
    step();
    ack_i = 8'h00;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL early_ready_spacing: got %b want 1", in_ready); end
  endtask

  task automatic test_flow_control;
    logic got;
    en       = 1'b0;
    in_idx   = 3'd7;
    in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flow_ready_en0: got %b want 0", in_ready); end
    step();
    step();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL flow_no_accept: got %h want 00", y); end
    en = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flow_ready_en1: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (y !== 8'h80) begin errors++; $display("FAIL flow_accept_y: got %h want 80", y); end
    // Dropping en mid-transaction must not abort it.
    en    = 1'b0;
    ack_i = 8'h80;
    got   = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (done_o === 1'b1) got = 1'b1;
    end
    ack_i = 8'h00;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL flow_done_wait: got %b want 1 within 10 cycles", got); end
    checks++; if (done_idx !== 3'd7) begin errors++; $display("FAIL flow_done_idx: got %0d want 7", done_idx); end
    step();
    en = 1'b1;
  endtask

  task automatic test_reset_mid_drive;
    logic got;
    logic saw_done;
    accept(3'd1);
    checks++; if (y !== 8'h02) begin errors++; $display("FAIL rstmid_y: got %h want 02", y); end
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL rstmid_y_drop: got %h want 00", y); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", in_ready); end
    saw_done = done_o;
    step();
    saw_done = saw_done | done_o;
    step();
    saw_done = saw_done | done_o;
    rst_n = 1'b1;
    #1;
    saw_done = saw_done | done_o;
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b want 0", saw_done); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_back: got %b want 1", in_ready); end
    ack_i = 8'h01;
    accept(3'd0);
    checks++; if (y !== 8'h01) begin errors++; $display("FAIL rstmid_new_y: got %h want 01", y); end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (done_o === 1'b1) got = 1'b1;
    end
    ack_i = 8'h00;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL rstmid_new_done: got %b want 1 within 10 cycles", got); end
    checks++; if (done_idx !== 3'd0) begin errors++; $display("FAIL rstmid_new_done_idx: got %0d want 0", done_idx); end
    step();
  endtask

`ifdef ONEHOT_DISPATCH_TIMEOUT_EN
  task automatic test_timeout;
    accept(3'd4);
    for (int i = 0; i < 4; i++) step();
    checks++; if (y !== 8'h00) begin errors++; $display("FAIL to_y_drop: got %h want 00", y); end
    for (int i = 0; i < 15; i++) begin
      step();
      checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_early%0d: got %b want 0", i, timeout_o); end
    end
    step();
    checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", timeout_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL to_no_done: got %b want 0", done_o); end
    checks++; if (done_idx !== 3'd4) begin errors++; $display("FAIL to_done_idx: got %0d want 4", done_idx); end
    step();
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_width: got %b want 0", timeout_o); end
    accept(3'd4);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 15; i++) step();
    ack_i = 8'h10;
    step();
    ack_i = 8'h00;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL to_ack_wins_done: got %b want 1", done_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL to_ack_wins_timeout: got %b want 0", timeout_o); end
    step();
  endtask
`else
  task automatic test_unbounded_wait;
    accept(3'd4);
    ack_i = 8'h40;
    for (int i = 0; i < 24; i++) begin
      step();
      checks++; if ((done_o | timeout_o) !== 1'b0) begin errors++; $display("FAIL wait_pulse%0d: got done=%b timeout=%b want 0/0", i, done_o, timeout_o); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wait_ready: got %b want 0", in_ready); end
    ack_i = 8'h10;
    step();
    ack_i = 8'h00;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL wait_done: got %b want 1", done_o); end
    checks++; if (done_idx !== 3'd4) begin errors++; $display("FAIL wait_done_idx: got %0d want 4", done_idx); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_dispatch();
    test_early_and_wrong_ack();
    test_flow_control();
    test_reset_mid_drive();
`ifdef ONEHOT_DISPATCH_TIMEOUT_EN
    test_timeout();
`else
    test_unbounded_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
